active_demapper: RTL

Receive-side counterpart of the stream active mapper. Consumes the per-lane 8-bit symbol stream with its control-symbol flag and removes stuffing framing. Stuffing runs from a stuffing-start (8'hFA) to a stuffing-end (8'hFF) control symbol. The block recovers main-stream data bytes, tracks transfer-unit (TU) boundaries, reports per-TU data counts and flags framing violations. It sits after lane de-skew/descrambling and feeds the main-stream unsteering logic.

---
 rtl/dp_sym_pkg.sv | 17 +
 rtl/active_demapper_if.sv | 42 ++++
 rtl/active_demapper_tu_cnt.sv | 53 +++++
 rtl/active_demapper.sv | 117 +++++++++++
 4 files changed

// File: rtl/dp_sym_pkg.sv
// rtl/dp_sym_pkg.sv - shared DisplayPort-style stuffing symbol constants and FSM type
//
// Purpose: symbol codes used by both the transmit-side mapper and the
// receive-side demapper, plus the demapper framing-state enum.
// Ports: none (package).
package dp_sym_pkg;

  localparam logic [7:0] SYM_STUFF_START = 8'hFA;
  localparam logic [7:0] SYM_STUFF_END   = 8'hFF;
  localparam logic [7:0] SYM_STUFF_FILL  = 8'h00;

  typedef enum logic {
    ST_DATA  = 1'b0,
    ST_STUFF = 1'b1
  } dm_state_e;

endpackage

// File: rtl/active_demapper_if.sv
// rtl/active_demapper_if.sv - symbol-in / recovered-data-out bundle of the active demapper
//
// Purpose: groups the control inputs, the received symbol stream and the
// demapper results into one interface.
// master : upstream side (drives symbols, enable, err_clr; observes results)
// slave  : the demapper itself
// Signals:
//   dm_en, err_clr, in_valid, in_symbol[7:0], in_control_flag   (master -> slave)
//   dm_data[7:0], dm_data_valid, dm_stuff_active, dm_tu_done,
//   dm_tu_data_count[CNT_W-1:0], dm_err_pulse, dm_err_sticky  (slave -> master)
interface active_demapper_if #(
  parameter int TU_SIZE = 64,
  parameter int CNT_W   = $clog2(TU_SIZE + 1)
);

  logic             dm_en;
  logic             err_clr;
  logic             in_valid;
  logic [7:0]       in_symbol;
  logic             in_control_flag;

  logic [7:0]       dm_data;
  logic             dm_data_valid;
  logic             dm_stuff_active;
  logic             dm_tu_done;
  logic [CNT_W-1:0] dm_tu_data_count;
  logic             dm_err_pulse;
  logic             dm_err_sticky;

  modport master (
    output dm_en, err_clr, in_valid, in_symbol, in_control_flag,
    input  dm_data, dm_data_valid, dm_stuff_active, dm_tu_done,
           dm_tu_data_count, dm_err_pulse, dm_err_sticky
  );

  modport slave (
    input  dm_en, err_clr, in_valid, in_symbol, in_control_flag,
    output dm_data, dm_data_valid, dm_stuff_active, dm_tu_done,
           dm_tu_data_count, dm_err_pulse, dm_err_sticky
  );

endinterface

// File: rtl/active_demapper_tu_cnt.sv
// rtl/active_demapper_tu_cnt.sv - transfer-unit symbol index and per-TU data counter
//
// Purpose: counts accepted symbols modulo TU_SIZE and data symbols within the
// current TU; flags the last symbol of a TU.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear (demapper disabled)
//   accept       a symbol is consumed this cycle
//   is_data      the consumed symbol is a main-stream data byte
//   last_sym     combinational: this accepted symbol closes the TU
//   tu_total     combinational: data count of the TU including this symbol
module active_demapper_tu_cnt #(
  parameter int TU_SIZE = 64,
  parameter int CNT_W   = $clog2(TU_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  input  logic             is_data,
  output logic             last_sym,
  output logic [CNT_W-1:0] tu_total
);

  localparam int IDX_W = (TU_SIZE > 2) ? $clog2(TU_SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TU_SIZE - 1);

  logic [IDX_W-1:0] sym_idx;
  logic [CNT_W-1:0] tu_data_cnt;

  assign last_sym = accept && (sym_idx == IDX_LAST);
  // Never exceeds TU_SIZE, which CNT_W is sized to hold.
  assign tu_total = tu_data_cnt + CNT_W'(is_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_idx     <= '0;
      tu_data_cnt <= '0;
    end else if (clr) begin
      sym_idx     <= '0;
      tu_data_cnt <= '0;
    end else if (accept) begin
      if (last_sym) begin
        sym_idx     <= '0;
        tu_data_cnt <= '0;
      end else begin
        sym_idx     <= sym_idx + 1'b1;
        tu_data_cnt <= tu_total;
      end
    end
  end

endmodule

// File: rtl/active_demapper.sv
// rtl/active_demapper.sv - receive-side stuffing removal, TU tracking and framing checks
//
// Purpose: strips FA..FF stuffing runs from the per-lane symbol stream,
// outputs main-stream data bytes, reports per-TU data counts and flags
// framing violations. All outputs are registered (1-cycle latency).
// Ports:
//   clk    symbol clock
//   rst_n  asynchronous active-low reset
//   bus    active_demapper_if.slave (inputs dm_en, err_clr, in_valid,
//          in_symbol, in_control_flag; outputs dm_data, dm_data_valid,
//          dm_stuff_active, dm_tu_done, dm_tu_data_count, dm_err_pulse,
//          dm_err_sticky)
module active_demapper
  import dp_sym_pkg::*;
#(
  parameter int TU_SIZE = 64,
  parameter int CNT_W   = $clog2(TU_SIZE + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  active_demapper_if.slave   bus
);

  dm_state_e        state_q, state_d;
  logic             accept;
  logic             is_data;
  logic             err;
  logic             last_sym;
  logic [CNT_W-1:0] tu_total;

  logic [7:0]       data_q;
  logic             data_valid_q;
  logic             tu_done_q;
  logic [CNT_W-1:0] tu_count_q;
  logic             err_pulse_q;
  logic             err_sticky_q;

  assign accept = bus.dm_en && bus.in_valid;

  active_demapper_tu_cnt #(
    .TU_SIZE (TU_SIZE),
    .CNT_W   (CNT_W)
  ) u_tu_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!bus.dm_en),
    .accept   (accept),
    .is_data  (is_data),
    .last_sym (last_sym),
    .tu_total (tu_total)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_DATA;
    else        state_q <= state_d;
  end

  // All error causes of one symbol fold into the single err strobe.
  always_comb begin
    state_d = state_q;
    is_data = 1'b0;
    err     = 1'b0;
    if (accept) begin
      if (!bus.in_control_flag) begin
        if (state_q == ST_DATA)                     is_data = 1'b1;
        else if (bus.in_symbol != SYM_STUFF_FILL)   err     = 1'b1;
      end else begin
        case (bus.in_symbol)
          SYM_STUFF_START: begin
            if (state_q == ST_DATA) state_d = ST_STUFF;
            else                    err     = 1'b1;
          end
          SYM_STUFF_END: begin
            if (state_q == ST_STUFF) state_d = ST_DATA;
            else                     err     = 1'b1;
          end
          default: err = 1'b1;
        endcase
      end
      // A stuffing run may not straddle a TU boundary.
      if (last_sym && (state_d == ST_STUFF)) begin
        err     = 1'b1;
        state_d = ST_DATA;
      end
    end
    if (!bus.dm_en) state_d = ST_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      tu_done_q    <= 1'b0;
      tu_count_q   <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      data_valid_q <= is_data;
      tu_done_q    <= last_sym;
      err_pulse_q  <= err;
      if (is_data)  data_q     <= bus.in_symbol;
      if (last_sym) tu_count_q <= tu_total;
      // A new error beats a coincident clear; disabled block holds sticky.
      if (err)                           err_sticky_q <= 1'b1;
      else if (bus.dm_en && bus.err_clr) err_sticky_q <= 1'b0;
    end
  end

  assign bus.dm_data          = data_q;
  assign bus.dm_data_valid    = data_valid_q;
  assign bus.dm_stuff_active  = (state_q == ST_STUFF);
  assign bus.dm_tu_done       = tu_done_q;
  assign bus.dm_tu_data_count = tu_count_q;
  assign bus.dm_err_pulse     = err_pulse_q;
  assign bus.dm_err_sticky    = err_sticky_q;

endmodule
